trig_oneshot_array: RTL and testbench

Multi-channel, runtime-programmable successor to the single-channel fixed-length trigger stretcher. Converts per-channel trigger inputs into scaler-gate pulses in the 250 MHz trigger domain. The block sits between the trigger discriminator outputs and the scaler/rate counters. Each channel has a programmable pulse length, an optional retrigger (extend) mode, edge or level qualification, and a programmable holdoff dead time.

---
 rtl/trig_oneshot_pkg.sv | 20 ++
 rtl/trig_oneshot_array_if.sv | 36 +++
 rtl/trig_oneshot_chan.sv | 122 ++++++++++++
 rtl/trig_oneshot_array.sv | 43 ++++
 tb/tb_trig_oneshot_array.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/trig_oneshot_pkg.sv
// -----------------------------------------------------------------------------
// trig_oneshot_pkg
// Shared types and helpers for the multi-channel trigger one-shot array.
//   state_e  : per-channel FSM state (IDLE / ACTIVE / HOLDOFF), 2 bits
//   max_len  : maps a programmed pulse length of 0 to 1
// -----------------------------------------------------------------------------
package trig_oneshot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    // A zero-length pulse would never be visible, so it is stretched to 1 cycle.
    function automatic logic [31:0] max_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/trig_oneshot_array_if.sv
// -----------------------------------------------------------------------------
// trig_oneshot_array_if
// Bundles the trigger inputs, shared configuration and per-channel outputs.
//   trig_i    : per-channel triggers            (master -> slave)
//   len_i     : pulse length, 0 treated as 1    (master -> slave)
//   holdoff_i : dead cycles after a pulse       (master -> slave)
//   retrig_i  : 1 = reload length while active  (master -> slave)
//   edge_i    : 1 = rising-edge events, 0 = level events (master -> slave)
//   scal_o    : stretched scaler gate per channel (slave -> master)
//   accept_o  : 1-cycle strobe, pulse started or reloaded (slave -> master)
//   drop_o    : 1-cycle strobe, event ignored (slave -> master)
// -----------------------------------------------------------------------------
interface trig_oneshot_array_if #(
    parameter int NCH = 8,
    parameter int LW  = 8,
    parameter int HW  = 8
);
    logic [NCH-1:0] trig_i;
    logic [LW-1:0]  len_i;
    logic [HW-1:0]  holdoff_i;
    logic           retrig_i;
    logic           edge_i;
    logic [NCH-1:0] scal_o;
    logic [NCH-1:0] accept_o;
    logic [NCH-1:0] drop_o;

    modport master (
        output trig_i, len_i, holdoff_i, retrig_i, edge_i,
        input  scal_o, accept_o, drop_o
    );

    modport slave (
        input  trig_i, len_i, holdoff_i, retrig_i, edge_i,
        output scal_o, accept_o, drop_o
    );
endinterface

// File: rtl/trig_oneshot_chan.sv
// -----------------------------------------------------------------------------
// trig_oneshot_chan
// One trigger stretcher channel: edge/level qualification, IDLE/ACTIVE/HOLDOFF
// FSM with a shared down-counter, and three registered outputs.
//   clk250_i  : trigger-domain clock
//   rst_i     : asynchronous active-high reset
//   trig_i    : trigger input for this channel
//   len_i     : pulse length (0 -> 1), sampled when a pulse is loaded
//   holdoff_i : dead cycles, sampled when the pulse expires
//   retrig_i  : reload the length on an event while active
//   edge_i    : rising-edge (1) or level (0) qualification
//   scal_o    : registered ACTIVE indication
//   accept_o  : registered strobe, event started/reloaded a pulse
//   drop_o    : registered strobe, event ignored
// -----------------------------------------------------------------------------
module trig_oneshot_chan
    import trig_oneshot_pkg::*;
#(
    parameter int LW = 8,
    parameter int HW = 8
) (
    input  logic          clk250_i,
    input  logic          rst_i,
    input  logic          trig_i,
    input  logic [LW-1:0] len_i,
    input  logic [HW-1:0] holdoff_i,
    input  logic          retrig_i,
    input  logic          edge_i,
    output logic          scal_o,
    output logic          accept_o,
    output logic          drop_o
);
    localparam int CW = (LW > HW) ? LW : HW;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_e         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_trig_q;
    logic           r_acc_pend;
    logic           r_drop_pend;
    logic           r_scal;
    logic           r_accept;
    logic           r_drop;

    logic           w_ev;
    logic [CW-1:0]  w_len_eff;
    logic [CW-1:0]  w_hold_ext;

    assign w_ev       = edge_i ? (trig_i & ~r_trig_q) : trig_i;
    assign w_len_eff  = CW'(max_len(32'(len_i)));
    assign w_hold_ext = CW'(holdoff_i);

    // Channel FSM; the strobes are staged once so they line up with scal_o,
    // which itself reflects the state one cycle after the event.
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_trig_q    <= 1'b0;
            r_acc_pend  <= 1'b0;
            r_drop_pend <= 1'b0;
            r_scal      <= 1'b0;
            r_accept    <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_trig_q    <= trig_i;
            r_acc_pend  <= 1'b0;
            r_drop_pend <= 1'b0;
            r_scal      <= (r_state == ST_ACTIVE);
            r_accept    <= r_acc_pend;
            r_drop      <= r_drop_pend;
            case (r_state)
                ST_IDLE: begin
                    if (w_ev) begin
                        r_state    <= ST_ACTIVE;
                        r_cnt      <= w_len_eff;
                        r_acc_pend <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // A reload wins over expiry in the same cycle.
                    if (w_ev && retrig_i) begin
                        r_cnt      <= w_len_eff;
                        r_acc_pend <= 1'b1;
                    end else begin
                        r_drop_pend <= w_ev;
                        if (r_cnt == CNT_ONE) begin
                            if (w_hold_ext != CNT_ZERO) begin
                                r_state <= ST_HOLDOFF;
                                r_cnt   <= w_hold_ext;
                            end else begin
                                r_state <= ST_IDLE;
                                r_cnt   <= CNT_ZERO;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    r_drop_pend <= w_ev;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign scal_o   = r_scal;
    assign accept_o = r_accept;
    assign drop_o   = r_drop;

endmodule

// File: rtl/trig_oneshot_array.sv
// -----------------------------------------------------------------------------
// trig_oneshot_array
// NCH independent trigger stretchers sharing one configuration.
//   clk250_i : trigger-domain clock
//   rst_i    : asynchronous active-high reset
//   bus      : trig_oneshot_array_if.slave (triggers, config, outputs)
// -----------------------------------------------------------------------------
module trig_oneshot_array #(
    parameter int NCH = 8,
    parameter int LW  = 8,
    parameter int HW  = 8
) (
    input  logic                  clk250_i,
    input  logic                  rst_i,
    trig_oneshot_array_if.slave   bus
);
    wire [NCH-1:0] w_scal;
    wire [NCH-1:0] w_accept;
    wire [NCH-1:0] w_drop;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        trig_oneshot_chan #(
            .LW (LW),
            .HW (HW)
        ) u_chan (
            .clk250_i  (clk250_i),
            .rst_i     (rst_i),
            .trig_i    (bus.trig_i[g]),
            .len_i     (bus.len_i),
            .holdoff_i (bus.holdoff_i),
            .retrig_i  (bus.retrig_i),
            .edge_i    (bus.edge_i),
            .scal_o    (w_scal[g]),
            .accept_o  (w_accept[g]),
            .drop_o    (w_drop[g])
        );
    end

    assign bus.scal_o   = w_scal;
    assign bus.accept_o = w_accept;
    assign bus.drop_o   = w_drop;

endmodule

// File: tb/tb_trig_oneshot_array.sv
// -----------------------------------------------------------------------------
// tb_trig_oneshot_array
// Directed scenarios plus randomized traffic, checked every cycle against a
// timestamp-based model of each channel (pulse end / holdoff end times).
// -----------------------------------------------------------------------------
module tb_trig_oneshot_array;
    logic clk;
    logic rst;

    trig_oneshot_array_if #(.NCH(8), .LW(8), .HW(8)) bus ();

    trig_oneshot_array #(.NCH(8), .LW(8), .HW(8)) dut (
        .clk250_i (clk),
        .rst_i    (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_n  = 0;
    int total_n = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Each channel is described by the last edge index it is ACTIVE after
    // (act_until) and the last edge index it is in holdoff after (hold_until).
    int          act_until  [8];
    int          hold_until [8];
    int          m_t;
    logic [7:0]  m_prev;
    logic [7:0]  s1_scal, s1_acc, s1_drop;
    logic [7:0]  e_scal, e_acc, e_drop;
    int          au, hu, ml;
    logic        mev, mact, mhold;
    logic [7:0]  n_scal, n_acc, n_drop;

    // Model step on every clock edge; results become visible one edge later.
    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 8; c++) begin
                act_until[c]  <= -10;
                hold_until[c] <= -10;
            end
            m_t     <= 0;
            m_prev  <= 8'd0;
            s1_scal <= 8'd0; s1_acc <= 8'd0; s1_drop <= 8'd0;
            e_scal  <= 8'd0; e_acc  <= 8'd0; e_drop  <= 8'd0;
        end else begin
            ml = (bus.len_i == 8'd0) ? 1 : int'(bus.len_i);
            for (int c = 0; c < 8; c++) begin
                au    = act_until[c];
                hu    = hold_until[c];
                mev   = bus.edge_i ? (bus.trig_i[c] & ~m_prev[c]) : bus.trig_i[c];
                mact  = (m_t - 1 <= au);
                mhold = !mact && (m_t - 1 <= hu);
                n_acc[c]  = 1'b0;
                n_drop[c] = 1'b0;
                if (mev && ((!mact && !mhold) || (mact && bus.retrig_i))) begin
                    au = m_t + ml - 1;
                    hu = au;
                    n_acc[c] = 1'b1;
                end else begin
                    n_drop[c] = mev;
                    if (mact && (m_t - 1 == au)) hu = au + int'(bus.holdoff_i);
                end
                n_scal[c] = (m_t <= au);
                act_until[c]  <= au;
                hold_until[c] <= hu;
            end
            e_scal  <= s1_scal; e_acc <= s1_acc; e_drop <= s1_drop;
            s1_scal <= n_scal;  s1_acc <= n_acc; s1_drop <= n_drop;
            m_prev  <= bus.trig_i;
            m_t     <= m_t + 1;
        end
    end

    // Per-cycle comparison, well away from either clock edge.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            chk("scal_in_reset",   32'(bus.scal_o),   32'd0);
            chk("accept_in_reset", 32'(bus.accept_o), 32'd0);
            chk("drop_in_reset",   32'(bus.drop_o),   32'd0);
        end else begin
            chk("scal",   32'(bus.scal_o),   32'(e_scal));
            chk("accept", 32'(bus.accept_o), 32'(e_acc));
            chk("drop",   32'(bus.drop_o),   32'(e_drop));
        end
    end

    // ---------------- directed helpers ----------------
    int sel, idx, hi, acc_n, drop_n, first_hi, last_hi, drop_idx;

    task automatic clr(input int ch);
        sel = ch; idx = 0; hi = 0; acc_n = 0; drop_n = 0;
        first_hi = -1; last_hi = -1; drop_idx = -1;
    endtask

    // Sample index k is the falling edge after rising edge k of the run.
    task automatic tick();
        @(negedge clk);
        if (bus.scal_o[sel]) begin
            hi++;
            last_hi = idx;
            if (first_hi < 0) first_hi = idx;
        end
        if (bus.accept_o[sel]) acc_n++;
        if (bus.drop_o[sel]) begin
            drop_n++;
            if (drop_idx < 0) drop_idx = idx;
        end
        idx++;
    endtask

    // pat[k] is the trigger level sampled at rising edge k.
    task automatic run(input int ch, input logic [63:0] pat, input int n);
        for (int k = 0; k < n; k++) begin
            bus.trig_i[ch] = pat[k];
            tick();
        end
        bus.trig_i[ch] = 1'b0;
    endtask

    task automatic cfg(input int len, input int hold, input logic rt, input logic ed);
        bus.len_i     = 8'(len);
        bus.holdoff_i = 8'(hold);
        bus.retrig_i  = rt;
        bus.edge_i    = ed;
    endtask

    initial begin
        rst = 1'b1;
        bus.trig_i = 8'd0;
        cfg(1, 0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("reset_scal",   32'(bus.scal_o),   32'd0);
        chk("reset_accept", 32'(bus.accept_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a 20-cycle pulse, then a fresh pulse.
        cfg(20, 0, 1'b0, 1'b1);
        clr(0);
        run(0, 64'h1, 5);
        chk("pre_reset_high_cycles", 32'(hi), 32'd4);
        rst = 1'b1;
        #1;
        chk("scal0_cleared_by_reset", 32'(bus.scal_o[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr(0);
        run(0, 64'h1, 25);
        chk("after_reset_len20_high", 32'(hi), 32'd20);
        chk("after_reset_len20_first", 32'(first_hi), 32'd1);
        chk("after_reset_len20_last", 32'(last_hi), 32'd20);

        // Fixed length 32 on channel 3, then length 0.
        cfg(32, 0, 1'b0, 1'b1);
        clr(3);
        run(3, 64'h1, 36);
        chk("len32_high", 32'(hi), 32'd32);
        chk("len32_first", 32'(first_hi), 32'd1);
        chk("len32_accepts", 32'(acc_n), 32'd1);
        cfg(0, 0, 1'b0, 1'b1);
        clr(3);
        run(3, 64'h1, 4);
        chk("len0_high", 32'(hi), 32'd1);
        chk("len0_first", 32'(first_hi), 32'd1);

        // Non-retrigger: second event at t=4 is dropped.
        cfg(10, 0, 1'b0, 1'b1);
        clr(1);
        run(1, 64'h11, 14);
        chk("noretrig_high", 32'(hi), 32'd10);
        chk("noretrig_drops", 32'(drop_n), 32'd1);
        chk("noretrig_drop_idx", 32'(drop_idx), 32'd5);

        // Retrigger on the expiry cycle extends to 19 continuous cycles.
        cfg(10, 0, 1'b1, 1'b1);
        clr(2);
        run(2, 64'h201, 24);
        chk("retrig_high", 32'(hi), 32'd19);
        chk("retrig_last", 32'(last_hi), 32'd19);
        chk("retrig_accepts", 32'(acc_n), 32'd2);

        // Level mode with holdoff; channel 7 driven independently.
        cfg(4, 3, 1'b0, 1'b0);
        clr(0);
        for (int k = 0; k < 24; k++) begin
            bus.trig_i[0] = (k < 20);
            bus.trig_i[7] = (k >= 3 && k < 6);
            tick();
        end
        bus.trig_i = 8'd0;
        chk("level_high", 32'(hi), 32'd12);
        chk("level_accepts", 32'(acc_n), 32'd3);
        chk("level_drops", 32'(drop_n), 32'd17);
        repeat (10) @(negedge clk);

        // Randomized traffic with occasional config changes and resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0)
                cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            bus.trig_i = 8'($urandom & $urandom & $urandom);
        end
        bus.trig_i = 8'd0;
        repeat (30) @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
